// File: rtl/sub_serial_ov_pkg.sv
// Shared definitions for the nibble-serial subtractor: slice width, FSM encoding,
// and the nibble-counter width helper.
package sub_serial_ov_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes WIDTH/4 nibbles; never below one bit.
    function automatic int cnt_w(input int width);
        int n;
        n = $clog2(width / NIB_W);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/sub_serial_ov_sub4_slice.sv
// One 4-bit carry-lookahead slice computing a + ~b + ci, exposing the carry into
// bit 3 (c3) as well as the carry out (co) so the caller can form signed overflow.
import sub_serial_ov_pkg::*;

module sub4_slice (
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci,
    output logic [NIB_W-1:0] s,
    output logic             c3,
    output logic             co
);

    logic [NIB_W-1:0] bn, g, p;
    logic [NIB_W:0]   c;

    assign bn = ~b;
    assign g  = a & bn;
    assign p  = a ^ bn;

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s  = p ^ c[NIB_W-1:0];
    assign c3 = c[3];
    assign co = c[4];

endmodule

// File: rtl/sub_serial_ov.sv
// Nibble-serial a - b over WIDTH/4 cycles using a single reused sub4_slice.
// Optional macro SUB_SERIAL_SATURATE_EN clamps diff on signed overflow.
import sub_serial_ov_pkg::*;

module sub_serial_ov #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ov,
    output logic             zero,
    output logic             negative
);

    localparam int N  = WIDTH / NIB_W;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0]       a_sh, b_sh;
    logic [WIDTH-NIB_W-1:0] diff_sh;
    logic [CW-1:0]          cnt;
    logic                   carry;
    logic [NIB_W-1:0]       sum;
    logic                   s_c3, s_co;
    logic [WIDTH-1:0]       wrap_d, final_d;
`ifdef SUB_SERIAL_SATURATE_EN
    logic                   a_neg;
`endif

    sub4_slice u_slice (
        .a  (a_sh[NIB_W-1:0]),
        .b  (b_sh[NIB_W-1:0]),
        .ci (carry),
        .s  (sum),
        .c3 (s_c3),
        .co (s_co)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Only valid on the last RUN edge, when diff_sh holds the lower N-1 nibbles.
    always_comb begin
        wrap_d  = {sum, diff_sh};
        final_d = wrap_d;
`ifdef SUB_SERIAL_SATURATE_EN
        if (s_c3 ^ s_co)
            final_d = a_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            ov       <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
`ifdef SUB_SERIAL_SATURATE_EN
            a_neg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    carry <= 1'b1;
                    cnt   <= '0;
`ifdef SUB_SERIAL_SATURATE_EN
                    a_neg <= a[WIDTH-1];
`endif
                end
                RUN: begin
                    a_sh    <= a_sh >> NIB_W;
                    b_sh    <= b_sh >> NIB_W;
                    diff_sh <= wrap_d[WIDTH-1:NIB_W];
                    carry   <= s_co;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff     <= final_d;
                        borrow   <= ~s_co;
                        ov       <= s_c3 ^ s_co;
                        zero     <= (final_d == '0);
                        negative <= final_d[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_ov.sv
// Self-checking bench for sub_serial_ov (WIDTH=16): spec vectors, random ops
// against an arithmetic reference, held-start, and reset-abort sequences.
module tb_sub_serial_ov;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [WIDTH-1:0] a_i, b_i;
    logic             busy, done, borrow, ov, zero, negative;
    logic [WIDTH-1:0] diff;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [WIDTH-1:0] a, b, d;
        logic             br, ov, z, n;
    } vec_t;

    sub_serial_ov #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a_i), .b(b_i),
        .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ov(ov),
        .zero(zero), .negative(negative)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic vec_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vec_t v;
        int   sa, sb, sd;
        v.a  = a;
        v.b  = b;
        v.d  = a - b;
        v.br = (int'(a) < int'(b));
        sa   = (int'(a) >= 32768) ? int'(a) - 65536 : int'(a);
        sb   = (int'(b) >= 32768) ? int'(b) - 65536 : int'(b);
        sd   = sa - sb;
        v.ov = (sd > 32767) || (sd < -32768);
`ifdef SUB_SERIAL_SATURATE_EN
        if (v.ov) v.d = (sa < 0) ? 16'h8000 : 16'h7FFF;
`endif
        v.z = (v.d == 0);
        v.n = (int'(v.d) >= 32768);
        return v;
    endfunction

    task automatic check_res(input string tag, input vec_t e);
        chk({tag, ".diff"}, 32'(diff), 32'(e.d));
        chk({tag, ".borrow"}, 32'(borrow), 32'(e.br));
        chk({tag, ".ov"}, 32'(ov), 32'(e.ov));
        chk({tag, ".zero"}, 32'(zero), 32'(e.z));
        chk({tag, ".neg"}, 32'(negative), 32'(e.n));
    endtask

    // Launch one op, scramble operands after E0, return edges from E0 to done.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; a_i = a; b_i = b;
        @(posedge clk); #1;
        start = 1'b0; a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
        chk("busy_after_E0", 32'(busy), 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_and_check(input string tag, input vec_t e);
        int lat;
        run_op(e.a, e.b, lat);
        chk({tag, ".latency"}, 32'(lat), 32'(N));
        check_res(tag, e);
        @(posedge clk); #1;
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        check_res({tag, ".held"}, e);
    endtask

    vec_t vecs[7];

    initial begin
        int   lat, ndone, first_done, second_done, stray;
        vec_t e0, e1, r;

        vecs[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef SUB_SERIAL_SATURATE_EN
        vecs[3] = '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
`else
        vecs[3] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0F00, 16'hF1FF, 1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        check_res("reset", '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); reset = 1'b0;

        foreach (vecs[i]) op_and_check($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) begin
            r = model(WIDTH'($urandom), WIDTH'($urandom));
            op_and_check($sformatf("rnd%0d", i), r);
        end

        // start held high for two full operations while operands churn every cycle.
        @(negedge clk);
        start = 1'b1; a_i = 16'h4321; b_i = 16'h1111;
        e0 = model(a_i, b_i);
        e1 = e0;
        ndone = 0; first_done = -1; second_done = -1;
        for (int e = 0; e <= 2 * N + 3; e++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (ndone == 0) begin first_done = e; check_res("held.op1", e0); end
                else begin second_done = e; check_res("held.op2", e1); end
                ndone++;
            end
            a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
            if (e + 1 == N + 2) e1 = model(a_i, b_i);
        end
        start = 1'b0;
        chk("held.done_count", 32'(ndone), 32'd2);
        chk("held.first_done_edge", 32'(first_done), 32'(N));
        chk("held.second_done_edge", 32'(second_done), 32'(2 * N + 2));
        stray = 0;
        repeat (2 * N) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) stray++;
        end
        chk("held.idle_after", 32'(stray), 32'd0);

        // Reset at the second RUN edge abandons the op.
        op_and_check("pre_reset", vecs[1]);
        @(negedge clk);
        start = 1'b1; a_i = 16'h0005; b_i = 16'h0003;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        check_res("midrst", '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        stray = 0;
        repeat (2 * N) begin
            @(posedge clk); #1;
            if (done === 1'b1) stray++;
        end
        chk("midrst.no_done", 32'(stray), 32'd0);
        op_and_check("post_reset", vecs[6]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
